// File: rtl/wavetable_osc.sv
// DDS wavetable oscillator: advances a phase per sample tick, reads the waveform RAM and emits
// a two's-complement sample. Define WT_INTERP_EN for linear interpolation between adjacent entries.
module wavetable_osc #(
    parameter int unsigned PHASE_W = 24,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               note_on,
    input  logic [PHASE_W-1:0] tune_word,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_ce,
    output logic               ram_re,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        StIdle, StFetch0, StCap0, StFetch1, StCap1, StInterp, StOut
    } state_e;

    // Flipping the MSB converts offset-binary table data to two's complement.
    localparam logic [DATA_W-1:0] SignFlip = {1'b1, {(DATA_W-1){1'b0}}};

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   sample_q;
    logic                mute_valid_q;
    logic                overrun_q;
    logic                accept;

    assign accept = sample_tick && (state_q == StIdle);

`ifdef WT_INTERP_EN
    logic [DATA_W-1:0]        s0_q, s1_q;
    logic [7:0]               frac_q;
    logic signed [DATA_W:0]   diff;
    logic signed [DATA_W+9:0] prod;
    logic [DATA_W-1:0]        interp_y;
    logic                     unused_prod;

    always_comb begin
        diff     = $signed({1'b0, s1_q}) - $signed({1'b0, s0_q});
        prod     = diff * $signed({1'b0, frac_q});
        interp_y = s0_q + prod[DATA_W+7:8];
    end

    assign unused_prod = ^{prod[DATA_W+9:DATA_W+8], prod[7:0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (sample_tick && note_on) state_d = StFetch0;
            StFetch0: state_d = StCap0;
`ifdef WT_INTERP_EN
            StCap0:   state_d = StFetch1;
            StFetch1: state_d = StCap1;
            StCap1:   state_d = StInterp;
            StInterp: state_d = StOut;
`else
            StCap0:   state_d = StOut;
`endif
            StOut:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_ce       = (state_q == StFetch0) || (state_q == StFetch1);
        ram_re       = ram_ce;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        ram_addr     = ram_addr_q;
        busy         = (state_q != StIdle);
        sample       = sample_q;
        sample_valid = (state_q == StOut) || mute_valid_q;
        overrun      = overrun_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= '0;
            ram_addr_q   <= '0;
            sample_q     <= '0;
            mute_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef WT_INTERP_EN
            s0_q         <= '0;
            s1_q         <= '0;
            frac_q       <= '0;
`endif
        end else begin
            mute_valid_q <= 1'b0;
            if (sample_tick && !accept) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (accept && note_on) begin
                        ram_addr_q <= phase_q[PHASE_W-1 -: ADDR_W];
                        phase_q    <= phase_q + tune_word;
`ifdef WT_INTERP_EN
                        frac_q     <= phase_q[PHASE_W-ADDR_W-1 -: 8];
`endif
                    end else if (accept) begin
                        phase_q      <= '0;
                        sample_q     <= '0;
                        mute_valid_q <= 1'b1;
                    end
                end
`ifdef WT_INTERP_EN
                StCap0: begin
                    s0_q       <= ram_rdata;
                    ram_addr_q <= ram_addr_q + ADDR_W'(1);
                end
                StCap1:   s1_q     <= ram_rdata;
                StInterp: sample_q <= interp_y ^ SignFlip;
`else
                // Sample is loaded here so that it is stable throughout the OUT cycle.
                StCap0:   sample_q <= ram_rdata ^ SignFlip;
`endif
                default: ;
            endcase
        end
    end

endmodule
